// File: rtl/branch_control_unit_if.sv
// Bundles the instruction/handshake signals of the branch control unit.
// The master side (fetch/DMA stage) drives the instruction fields and
// resume; the slave side (the unit itself) drives redirect and status.
interface branch_control_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic                  JMP_ENB;
  logic [4:0]            opcode;
  logic [DATA_WIDTH-1:0] f_register_value;
  logic [DATA_WIDTH-1:0] t_register_value;
  logic [PC_WIDTH-1:0]   immediate;
  logic [PC_WIDTH-1:0]   PC_pos;
  logic                  resume;

  logic                  ready;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  JMP_flag;
  logic                  CALL_flag;
  logic                  RET_flag;
  logic                  halted;
  logic                  fault;
  logic                  stack_overflow;
  logic                  stack_underflow;
  logic [CNT_W-1:0]      stack_count;

  modport master (
    output JMP_ENB, opcode, f_register_value, t_register_value, immediate,
           PC_pos, resume,
    input  ready, redirect_valid, redirect_pc, JMP_flag, CALL_flag, RET_flag,
           halted, fault, stack_overflow, stack_underflow, stack_count
  );

  modport slave (
    input  JMP_ENB, opcode, f_register_value, t_register_value, immediate,
           PC_pos, resume,
    output ready, redirect_valid, redirect_pc, JMP_flag, CALL_flag, RET_flag,
           halted, fault, stack_overflow, stack_underflow, stack_count
  );
endinterface

// File: rtl/branch_control_unit.sv
// Branch control unit: resolves jumps, conditional/relative jumps,
// CALL/RET (through an internal return-address stack) and HALT into a
// registered PC redirect one cycle after acceptance. RUN/HALTED/FAULT
// state machine with resume handshake; FAULT is left only via reset.
// Optional feature macro: BCU_STACK_WRAP_EN makes the return-address
// stack circular (CALL on a full stack overwrites the oldest entry).
module branch_control_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  branch_control_unit_if.slave bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef BCU_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [4:0] OP_JMP    = 5'b00001;
  localparam logic [4:0] OP_JMPC   = 5'b00101;
  localparam logic [4:0] OP_JMPI   = 5'b01001;
  localparam logic [4:0] OP_JMPFI  = 5'b01010;
  localparam logic [4:0] OP_JMPBI  = 5'b01011;
  localparam logic [4:0] OP_JMPCI  = 5'b01101;
  localparam logic [4:0] OP_JMPCFI = 5'b01110;
  localparam logic [4:0] OP_JMPCBI = 5'b01111;
  localparam logic [4:0] OP_CALL   = 5'b10000;
  localparam logic [4:0] OP_CALLI  = 5'b10001;
  localparam logic [4:0] OP_RET    = 5'b10010;
  localparam logic [4:0] OP_HALT   = 5'b11000;

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                jmp_flag_q, jmp_flag_d;
  logic                call_flag_q, call_flag_d;
  logic                ret_flag_q, ret_flag_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                push, pop;
  logic                full, empty, cond_taken;
  logic [PC_WIDTH-1:0] f_pc, jmp_tgt, top_pc, ret_addr;

  assign f_pc       = bus.f_register_value[PC_WIDTH-1:0];
  assign full       = (count_q == CNT_W'(STACK_DEPTH));
  assign empty      = (count_q == '0);
  assign cond_taken = |bus.t_register_value;
  assign top_pc     = stack_q[ptr_q - PTR_W'(1)];
  assign ret_addr   = bus.PC_pos + PC_WIDTH'(1);

  // Jump target shared by the unconditional and conditional forms:
  // bit 3 selects immediate forms, bits [1:0] pick absolute/forward/back.
  always_comb begin
    jmp_tgt = f_pc;
    if (bus.opcode[3]) begin
      unique case (bus.opcode[1:0])
        2'b10:   jmp_tgt = bus.PC_pos + bus.immediate;
        2'b11:   jmp_tgt = bus.PC_pos - bus.immediate;
        default: jmp_tgt = bus.immediate;
      endcase
    end
  end

  // Next-state, redirect and stack-pointer decision for the current cycle.
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first so no latch is inferred on untaken paths.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    jmp_flag_d       = 1'b0;
    call_flag_d      = 1'b0;
    ret_flag_d       = 1'b0;
    overflow_d       = overflow_q;
    underflow_d      = underflow_q;
    push             = 1'b0;
    pop              = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.JMP_ENB) begin
          unique case (bus.opcode)
            OP_JMP, OP_JMPI, OP_JMPFI, OP_JMPBI: begin
              redirect_valid_d = 1'b1;
              jmp_flag_d       = 1'b1;
              redirect_pc_d    = jmp_tgt;
            end
            OP_JMPC, OP_JMPCI, OP_JMPCFI, OP_JMPCBI: begin
              if (cond_taken) begin
                redirect_valid_d = 1'b1;
                jmp_flag_d       = 1'b1;
                redirect_pc_d    = jmp_tgt;
              end
            end
            OP_CALL, OP_CALLI: begin
              if (full && !WRAP_EN) begin
                overflow_d = 1'b1;
                state_d    = ST_FAULT;
              end else begin
                push             = 1'b1;
                redirect_valid_d = 1'b1;
                call_flag_d      = 1'b1;
                redirect_pc_d    = (bus.opcode == OP_CALL) ? f_pc : bus.immediate;
              end
            end
            OP_RET: begin
              if (empty) begin
                underflow_d = 1'b1;
                state_d     = ST_FAULT;
              end else begin
                pop              = 1'b1;
                redirect_valid_d = 1'b1;
                ret_flag_d       = 1'b1;
                redirect_pc_d    = top_pc;
              end
            end
            OP_HALT: begin
              redirect_valid_d = 1'b1;
              jmp_flag_d       = 1'b1;
              redirect_pc_d    = bus.PC_pos;
              state_d          = ST_HALTED;
            end
            default: ;
          endcase
        end
      end
      ST_HALTED: if (bus.resume) state_d = ST_RUN;
      default: ;
    endcase

    // A wrapping push on a full stack overwrites the oldest slot, so the
    // pointer still advances but the occupancy stays at STACK_DEPTH.
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end

    ready_d  = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALTED);
    fault_d  = (state_d == ST_FAULT);
  end

  // Control state, registered outputs and stack bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      ready_q          <= 1'b1;
      halted_q         <= 1'b0;
      fault_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      jmp_flag_q       <= 1'b0;
      call_flag_q      <= 1'b0;
      ret_flag_q       <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      ptr_q            <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      ready_q          <= ready_d;
      halted_q         <= halted_d;
      fault_q          <= fault_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      jmp_flag_q       <= jmp_flag_d;
      call_flag_q      <= call_flag_d;
      ret_flag_q       <= ret_flag_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
      ptr_q            <= ptr_d;
      count_q          <= count_d;
    end
  end

  // Return-address storage, written at the accepting edge of a CALL.
  // NOTE: the array is not reset; count_q/ptr_q define which entries are
  // live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_q] <= ret_addr;
  end

  generate
    if (DATA_WIDTH > PC_WIDTH) begin : g_f_upper
      logic unused_f_upper;
      assign unused_f_upper = ^bus.f_register_value[DATA_WIDTH-1:PC_WIDTH];
    end
  endgenerate

  assign bus.ready           = ready_q;
  assign bus.halted          = halted_q;
  assign bus.fault           = fault_q;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.JMP_flag        = jmp_flag_q;
  assign bus.CALL_flag       = call_flag_q;
  assign bus.RET_flag        = ret_flag_q;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;
  assign bus.stack_count     = count_q;
endmodule

// File: tb/tb_branch_control_unit.sv
// Self-checking bench for branch_control_unit. Every driven cycle pushes
// the expected redirect/flag pulse for the following cycle onto a queue;
// a monitor pops and compares it shortly after each rising edge. Status
// outputs (ready/halted/fault/sticky bits/stack_count) are checked inline.
module tb_branch_control_unit;
  localparam int PW = 16;
  localparam int DW = 32;
  localparam int SD = 8;
  localparam int CW = $clog2(SD) + 1;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00111;
  localparam logic [4:0] OP_JMP    = 5'b00001;
  localparam logic [4:0] OP_JMPC   = 5'b00101;
  localparam logic [4:0] OP_JMPI   = 5'b01001;
  localparam logic [4:0] OP_JMPFI  = 5'b01010;
  localparam logic [4:0] OP_JMPBI  = 5'b01011;
  localparam logic [4:0] OP_JMPCI  = 5'b01101;
  localparam logic [4:0] OP_JMPCFI = 5'b01110;
  localparam logic [4:0] OP_JMPCBI = 5'b01111;
  localparam logic [4:0] OP_CALL   = 5'b10000;
  localparam logic [4:0] OP_CALLI  = 5'b10001;
  localparam logic [4:0] OP_RET    = 5'b10010;
  localparam logic [4:0] OP_HALT   = 5'b11000;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] pc;
    logic          j;
    logic          c;
    logic          r;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_control_unit_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .STACK_DEPTH(SD)) bus ();

  branch_control_unit #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex_none();
    return '0;
  endfunction

  function automatic exp_t ex_red(input logic [PW-1:0] pc, input logic j, input logic c,
                                  input logic r);
    exp_t e;
    e.v = 1'b1; e.pc = pc; e.j = j; e.c = c; e.r = r;
    return e;
  endfunction

  // Scoreboard monitor: compare the pulse produced by the last edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.redirect_valid !== e.v || bus.JMP_flag !== e.j || bus.CALL_flag !== e.c ||
          bus.RET_flag !== e.r || (e.v && bus.redirect_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL redirect @%0t: got v=%b pc=%h jcr=%b%b%b, expected v=%b pc=%h jcr=%b%b%b",
                 $time, bus.redirect_valid, bus.redirect_pc, bus.JMP_flag, bus.CALL_flag,
                 bus.RET_flag, e.v, e.pc, e.j, e.c, e.r);
      end
    end
  end

  // Drive one instruction slot and record its expected result.
  task automatic drive(input logic en, input logic [4:0] op, input logic [DW-1:0] f,
                       input logic [DW-1:0] t, input logic [PW-1:0] imm,
                       input logic [PW-1:0] pc, input logic res, input exp_t e);
    @(negedge clk);
    bus.JMP_ENB = en; bus.opcode = op; bus.f_register_value = f;
    bus.t_register_value = t; bus.immediate = imm; bus.PC_pos = pc; bus.resume = res;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, OP_NOP, '0, '0, '0, '0, 1'b0, ex_none());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.JMP_ENB = 1'b0; bus.resume = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Status vector: {ready, halted, fault, overflow, underflow}.
  function automatic logic [4:0] status();
    return {bus.ready, bus.halted, bus.fault, bus.stack_overflow, bus.stack_underflow};
  endfunction

  task automatic test_reset();
    logic [PW+3:0] pulses;
    apply_reset();
    pulses = {bus.redirect_valid, bus.redirect_pc, bus.JMP_flag, bus.CALL_flag, bus.RET_flag};
    n_checks++;
    if (pulses !== '0) begin
      n_fail++; $display("FAIL reset_pulses: got %h, expected 0", pulses);
    end
    n_checks++;
    if (status() !== 5'b10000) begin
      n_fail++; $display("FAIL reset_status: got %b, expected 10000", status());
    end
    n_checks++;
    if (bus.stack_count !== CW'(0)) begin
      n_fail++; $display("FAIL reset_count: got %0d, expected 0", bus.stack_count);
    end
  endtask

  task automatic test_jumps();
    drive(1, OP_JMPI,   '0, '0, 16'h1234, 16'h0000, 0, ex_red(16'h1234, 1, 0, 0));
    idle();
    drive(1, OP_JMP,    32'h00AB_CDEF, '0, '0, 16'h0000, 0, ex_red(16'hCDEF, 1, 0, 0));
    drive(1, OP_JMPFI,  '0, '0, 16'h0020, 16'h0010, 0, ex_red(16'h0030, 1, 0, 0));
    drive(1, OP_JMPBI,  '0, '0, 16'h0005, 16'h0002, 0, ex_red(16'hFFFD, 1, 0, 0));
    drive(1, OP_JMPCFI, '0, 32'h0, 16'h0005, 16'h0002, 0, ex_none());
    drive(1, OP_JMPCFI, '0, 32'h8000_0000, 16'h0005, 16'h0002, 0, ex_red(16'h0007, 1, 0, 0));
    drive(1, OP_JMPC,   32'h0000_0055, 32'h1, '0, '0, 0, ex_red(16'h0055, 1, 0, 0));
    drive(1, OP_JMPCBI, '0, 32'h0, 16'h0003, 16'hFFFF, 0, ex_none());
    drive(1, OP_JMPCBI, '0, 32'h10, 16'h0003, 16'hFFFF, 0, ex_red(16'hFFFC, 1, 0, 0));
    drive(1, OP_JMPCI,  '0, 32'h3, 16'h0077, 16'h0100, 0, ex_red(16'h0077, 1, 0, 0));
    drive(1, OP_MISC,   32'h1234, 32'h1, 16'h0042, 16'h0042, 0, ex_none());
    n_checks++;
    if (status() !== 5'b10000) begin
      n_fail++; $display("FAIL nonctrl_status: got %b, expected 10000", status());
    end
    drive(1, OP_JMPFI,  '0, '0, 16'hFFFF, 16'h0003, 0, ex_red(16'h0002, 1, 0, 0));
    idle();
  endtask

  task automatic test_call_ret();
    drive(1, OP_CALLI, '0, '0, 16'h0100, 16'h0010, 0, ex_red(16'h0100, 0, 1, 0));
    n_checks++;
    if (bus.stack_count !== CW'(1)) begin
      n_fail++; $display("FAIL count_call1: got %0d, expected 1", bus.stack_count);
    end
    drive(1, OP_CALLI, '0, '0, 16'h0200, 16'h0100, 0, ex_red(16'h0200, 0, 1, 0));
    n_checks++;
    if (bus.stack_count !== CW'(2)) begin
      n_fail++; $display("FAIL count_call2: got %0d, expected 2", bus.stack_count);
    end
    drive(1, OP_RET, '0, '0, '0, 16'h0200, 0, ex_red(16'h0101, 0, 0, 1));
    n_checks++;
    if (bus.stack_count !== CW'(1)) begin
      n_fail++; $display("FAIL count_ret1: got %0d, expected 1", bus.stack_count);
    end
    drive(1, OP_RET, '0, '0, '0, 16'h0101, 0, ex_red(16'h0011, 0, 0, 1));
    n_checks++;
    if (bus.stack_count !== CW'(0)) begin
      n_fail++; $display("FAIL count_ret2: got %0d, expected 0", bus.stack_count);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1, OP_CALL, 32'hFFFF_4444, '0, '0, 16'h0020, 0, ex_red(16'h4444, 0, 1, 0));
    drive(1, OP_RET,  '0, '0, '0, 16'h4444, 0, ex_red(16'h0021, 0, 0, 1));
    drive(1, OP_JMPI, '0, '0, 16'h0ABC, 16'h0021, 0, ex_red(16'h0ABC, 1, 0, 0));
    idle();
    n_checks++;
    if (bus.stack_count !== CW'(0)) begin
      n_fail++; $display("FAIL b2b_count: got %0d, expected 0", bus.stack_count);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1, OP_RET, '0, '0, '0, 16'h0050, 0, ex_none());
    n_checks++;
    if (status() !== 5'b00101) begin
      n_fail++; $display("FAIL underflow_status: got %b, expected 00101", status());
    end
    drive(1, OP_JMPI, '0, '0, 16'h1111, 16'h0051, 0, ex_none());
    drive(1, OP_HALT, '0, '0, '0, 16'h0052, 1, ex_none());
    n_checks++;
    if (status() !== 5'b00101) begin
      n_fail++; $display("FAIL fault_stays: got %b, expected 00101", status());
    end
    apply_reset();
    n_checks++;
    if (status() !== 5'b10000) begin
      n_fail++; $display("FAIL underflow_reset: got %b, expected 10000", status());
    end
  endtask

`ifndef BCU_STACK_WRAP_EN
  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= SD; i++)
      drive(1, OP_CALLI, '0, '0, PW'(16'h1000 + i), PW'(i * 16), 0,
            ex_red(PW'(16'h1000 + i), 0, 1, 0));
    drive(1, OP_CALLI, '0, '0, 16'h1009, 16'h0090, 0, ex_none());
    n_checks++;
    if (status() !== 5'b00110) begin
      n_fail++; $display("FAIL overflow_status: got %b, expected 00110", status());
    end
    n_checks++;
    if (bus.stack_count !== CW'(SD)) begin
      n_fail++; $display("FAIL overflow_count: got %0d, expected %0d", bus.stack_count, SD);
    end
    drive(1, OP_RET, '0, '0, '0, 16'h0091, 0, ex_none());
    apply_reset();
    n_checks++;
    if (status() !== 5'b10000 || bus.stack_count !== CW'(0)) begin
      n_fail++; $display("FAIL overflow_reset: got status=%b count=%0d, expected 10000/0",
                         status(), bus.stack_count);
    end
  endtask
`else
  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= SD + 1; i++)
      drive(1, OP_CALLI, '0, '0, PW'(16'h2000 + i), PW'(i * 16), 0,
            ex_red(PW'(16'h2000 + i), 0, 1, 0));
    n_checks++;
    if (status() !== 5'b10000 || bus.stack_count !== CW'(SD)) begin
      n_fail++; $display("FAIL wrap_full: got status=%b count=%0d, expected 10000/%0d",
                         status(), bus.stack_count, SD);
    end
    for (int k = SD + 1; k >= 2; k--)
      drive(1, OP_RET, '0, '0, '0, 16'h3000, 0, ex_red(PW'(k * 16 + 1), 0, 0, 1));
    n_checks++;
    if (bus.stack_count !== CW'(0)) begin
      n_fail++; $display("FAIL wrap_empty: got %0d, expected 0", bus.stack_count);
    end
    drive(1, OP_RET, '0, '0, '0, 16'h3001, 0, ex_none());
    n_checks++;
    if (status() !== 5'b00101) begin
      n_fail++; $display("FAIL wrap_underflow: got %b, expected 00101", status());
    end
    apply_reset();
  endtask
`endif

  task automatic test_halt();
    apply_reset();
    drive(1, OP_HALT, '0, '0, '0, 16'h0040, 0, ex_red(16'h0040, 1, 0, 0));
    n_checks++;
    if (status() !== 5'b01000) begin
      n_fail++; $display("FAIL halt_status: got %b, expected 01000", status());
    end
    for (int i = 0; i < 3; i++)
      drive(1, OP_JMPI, '0, '0, 16'h1111, 16'h0041, 0, ex_none());
    n_checks++;
    if (status() !== 5'b01000) begin
      n_fail++; $display("FAIL halt_hold: got %b, expected 01000", status());
    end
    drive(1, OP_JMPI, '0, '0, 16'h1111, 16'h0041, 1, ex_none());
    n_checks++;
    if (status() !== 5'b10000) begin
      n_fail++; $display("FAIL resume_status: got %b, expected 10000", status());
    end
    drive(1, OP_JMPI, '0, '0, 16'h1111, 16'h0041, 0, ex_red(16'h1111, 1, 0, 0));
    drive(0, OP_NOP, '0, '0, '0, '0, 1, ex_none());
    n_checks++;
    if (status() !== 5'b10000) begin
      n_fail++; $display("FAIL resume_in_run: got %b, expected 10000", status());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1, OP_CALLI, '0, '0, 16'h0300, 16'h0030, 0, ex_red(16'h0300, 0, 1, 0));
    drive(1, OP_CALLI, '0, '0, 16'h0400, 16'h0300, 0, ex_red(16'h0400, 0, 1, 0));
    // Pulse from this accept is cut by the reset raised right after the edge.
    drive(1, OP_JMPI, '0, '0, 16'h3333, 16'h0400, 0, ex_none());
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.stack_count !== CW'(0) || status() !== 5'b10000) begin
      n_fail++; $display("FAIL reset_mid: got count=%0d status=%b, expected 0/10000",
                         bus.stack_count, status());
    end
    @(negedge clk);
    bus.JMP_ENB = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, OP_JMPI, '0, '0, 16'h0777, 16'h0000, 0, ex_red(16'h0777, 1, 0, 0));
    idle();
  endtask

  initial begin
    bus.JMP_ENB = 1'b0; bus.opcode = '0; bus.f_register_value = '0;
    bus.t_register_value = '0; bus.immediate = '0; bus.PC_pos = '0; bus.resume = 1'b0;
    test_reset();
    test_jumps();
    test_call_ret();
    test_back_to_back();
    test_underflow();
`ifndef BCU_STACK_WRAP_EN
    test_overflow();
`else
    test_wrap();
`endif
    test_halt();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
